// File: rtl/ride_dispatcher.sv
// ride_dispatcher
//   Ride-side controller paired with the waiting-queue counter. When the
//   operator enables it and at least BATCH people are waiting, it requests a
//   batch removal from the queue (drive_req/drive_ack handshake), then runs a
//   timed BOARD -> RIDE -> UNLOAD cycle and counts completed rides.
//
// Optional feature: define RIDE_ESTOP_EN to add the `estop` input
//   (synchronous, active-high emergency stop). Without the macro the port
//   does not exist.
//
// Ports:
//   CLOCK_50     in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   enable       in   operator permission to start new rides
//   queue_count  in   number of waiting people (unsigned)
//   drive_ack    in   queue confirms it subtracted BATCH
//   estop        in   emergency stop (only with RIDE_ESTOP_EN)
//   drive_req    out  request to subtract BATCH from the queue
//   phase        out  IDLE=0 REQUEST=1 BOARD=2 RIDE=3 UNLOAD=4
//   LEDG         out  one-hot phase LEDs [0]=REQ [1]=BOARD [2]=RIDE [3]=UNLOAD
//   HEX5         out  active-low 7-seg (a..g on [0:6]), remaining ticks
//   rides_done   out  completed-ride counter, saturating at 255
module ride_dispatcher #(
    parameter int BATCH        = 8,
    parameter int QCOUNT_W     = 5,
    parameter int TICK_DIV     = 24,
    parameter int BOARD_TICKS  = 2,
    parameter int RIDE_TICKS   = 5,
    parameter int UNLOAD_TICKS = 2
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                enable,
    input  logic [QCOUNT_W-1:0] queue_count,
    input  logic                drive_ack,
`ifdef RIDE_ESTOP_EN
    input  logic                estop,
`endif
    output logic                drive_req,
    output logic [2:0]          phase,
    output logic [3:0]          LEDG,
    output logic [0:6]          HEX5,
    output logic [7:0]          rides_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_BOARD  = 3'd2;
    localparam logic [2:0] S_RIDE   = 3'd3;
    localparam logic [2:0] S_UNLOAD = 3'd4;

    localparam logic [QCOUNT_W-1:0] BATCH_Q  = QCOUNT_W'(BATCH);
    localparam logic [3:0]          BOARD_N  = 4'(BOARD_TICKS);
    localparam logic [3:0]          RIDE_N   = 4'(RIDE_TICKS);
    localparam logic [3:0]          UNLOAD_N = 4'(UNLOAD_TICKS);
    localparam logic [0:6]          SEG_BLANK = 7'b111_1111;

    logic [2:0]          state_q, state_d;
    logic                drive_req_q, drive_req_d;
    logic [TICK_DIV-1:0] cnt_q, cnt_d;
    logic [3:0]          timer_q, timer_d;
    logic [7:0]          rides_q, rides_d;
    logic                abort_q, abort_d;
    logic                cnt_clr;
    logic                tick;
    logic                q_ok;
    logic                estop_w;

`ifdef RIDE_ESTOP_EN
    assign estop_w = estop;
`else
    assign estop_w = 1'b0;
`endif

    assign tick = &cnt_q;
    assign q_ok = (queue_count >= BATCH_Q);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rides_d = rides_q;
        abort_d = abort_q;
        cnt_clr = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && q_ok && !estop_w)
                    state_d = S_REQ;
            end
            S_REQ: begin
                // Ack wins over any withdraw condition: once the queue has
                // subtracted the batch those riders must be served.
                if (drive_ack) begin
                    state_d = S_BOARD;
                    timer_d = BOARD_N;
                    cnt_clr = 1'b1;
                end else if (!enable || !q_ok || estop_w) begin
                    state_d = S_IDLE;
                end
            end
            S_BOARD, S_RIDE: begin
                if (estop_w) begin
                    state_d = S_UNLOAD;
                    timer_d = UNLOAD_N;
                    cnt_clr = 1'b1;
                    abort_d = 1'b1;
                end else if (tick) begin
                    if (timer_q == 4'd1) begin
                        state_d = (state_q == S_BOARD) ? S_RIDE : S_UNLOAD;
                        timer_d = (state_q == S_BOARD) ? RIDE_N : UNLOAD_N;
                        cnt_clr = 1'b1;
                    end else begin
                        timer_d = timer_q - 4'd1;
                    end
                end
            end
            S_UNLOAD: begin
                if (tick) begin
                    if (timer_q == 4'd1) begin
                        state_d = S_IDLE;
                        timer_d = 4'd0;
                        abort_d = 1'b0;
                        if (!abort_q && rides_q != 8'hFF)
                            rides_d = rides_q + 8'd1;
                    end else begin
                        timer_d = timer_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = 4'd0;
                abort_d = 1'b0;
            end
        endcase
        // Clearing on timed-phase entry makes each phase exactly N ticks long.
        cnt_d       = cnt_clr ? '0 : cnt_q + TICK_DIV'(1);
        drive_req_d = (state_d == S_REQ);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            drive_req_q <= 1'b0;
            cnt_q       <= '0;
            timer_q     <= 4'd0;
            rides_q     <= 8'd0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            drive_req_q <= drive_req_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            rides_q     <= rides_d;
            abort_q     <= abort_d;
        end
    end

    assign phase      = state_q;
    assign drive_req  = drive_req_q;
    assign rides_done = rides_q;

    always_comb begin
        LEDG = 4'b0000;
        case (state_q)
            S_REQ:    LEDG = 4'b0001;
            S_BOARD:  LEDG = 4'b0010;
            S_RIDE:   LEDG = 4'b0100;
            S_UNLOAD: LEDG = 4'b1000;
            default:  LEDG = 4'b0000;
        endcase
    end

    // Digit table, active-low, literal bits left-to-right are segments a..g.
    always_comb begin
        HEX5 = SEG_BLANK;
        if (state_q == S_BOARD || state_q == S_RIDE || state_q == S_UNLOAD) begin
            case (timer_q)
                4'd0:    HEX5 = 7'b000_0001;
                4'd1:    HEX5 = 7'b100_1111;
                4'd2:    HEX5 = 7'b001_0010;
                4'd3:    HEX5 = 7'b000_0110;
                4'd4:    HEX5 = 7'b100_1100;
                4'd5:    HEX5 = 7'b010_0100;
                4'd6:    HEX5 = 7'b010_0000;
                4'd7:    HEX5 = 7'b000_1111;
                4'd8:    HEX5 = 7'b000_0000;
                4'd9:    HEX5 = 7'b000_0100;
                default: HEX5 = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: tb/tb_ride_dispatcher.sv
module tb_ride_dispatcher;

    localparam logic [0:6] BLANK = 7'b111_1111;
    localparam logic [0:6] D1    = 7'b100_1111;
    localparam logic [0:6] D2    = 7'b001_0010;
    localparam logic [0:6] D3    = 7'b000_0110;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [4:0] queue_count;
    logic       drive_ack;
    logic       estop;
    logic       drive_req;
    logic [2:0] phase;
    logic [3:0] ledg;
    logic [0:6] hex5;
    logic [7:0] rides_done;

    typedef struct {
        logic [2:0] ph;
        int         dur;   // cycles spent in the phase being left; 0 = not checked
        logic       req;
        logic [3:0] led;
        logic [0:6] hex;
        logic [7:0] rides;
    } exp_t;

    exp_t       expq[$];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_rides = 8'd0;

    ride_dispatcher #(
        .BATCH(8), .QCOUNT_W(5), .TICK_DIV(2),
        .BOARD_TICKS(2), .RIDE_TICKS(3), .UNLOAD_TICKS(1)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (rst),
        .enable     (enable),
        .queue_count(queue_count),
        .drive_ack  (drive_ack),
`ifdef RIDE_ESTOP_EN
        .estop      (estop),
`endif
        .drive_req  (drive_req),
        .phase      (phase),
        .LEDG       (ledg),
        .HEX5       (hex5),
        .rides_done (rides_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [2:0] ph, input int dur, input logic req,
                        input logic [3:0] led, input logic [0:6] hex, input logic [7:0] r);
        exp_t e;
        e.ph = ph; e.dur = dur; e.req = req; e.led = led; e.hex = hex; e.rides = r;
        expq.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            cyc();
            if (phase == 3'd0) return;
        end
        chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // Monitor: every phase change is an output event; pop and compare.
    logic [2:0] last_ph = 3'd0;
    int         dur     = 1;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_ph = 3'd0;
            dur     = 1;
        end else if (phase !== last_ph) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_phase: got %0d from %0d, none expected at %0t",
                         phase, last_ph, $time);
            end else begin
                e = expq.pop_front();
                chk("phase", 32'(phase), 32'(e.ph));
                if (e.dur != 0) chk("prev_dur", dur, e.dur);
                chk("drive_req", 32'(drive_req), 32'(e.req));
                chk("ledg", 32'(ledg), 32'(e.led));
                chk("hex5", 32'(hex5), 32'(e.hex));
                chk("rides", 32'(rides_done), 32'(e.rides));
            end
            last_ph = phase;
            dur     = 1;
        end else begin
            dur++;
        end
    end

    // en_mode: 0 drop enable with ack, 1 drop in BOARD, 2 drop in RIDE, 3 keep
    task automatic run_ride(input int ack_dly, input int en_mode, input int idle_dur);
        queue_count = 5'd12;
        enable      = 1'b1;
        push(3'd1, idle_dur, 1'b1, 4'b0001, BLANK, exp_rides);
        push(3'd2, ack_dly,  1'b0, 4'b0010, D2,    exp_rides);
        push(3'd3, 8,        1'b0, 4'b0100, D3,    exp_rides);
        push(3'd4, 12,       1'b0, 4'b1000, D1,    exp_rides);
        if (exp_rides != 8'hFF) exp_rides = exp_rides + 8'd1;
        push(3'd0, 4,        1'b0, 4'b0000, BLANK, exp_rides);
        cyc();
        repeat (ack_dly - 1) cyc();
        drive_ack = 1'b1;
        if (en_mode == 0) enable = 1'b0;
        cyc();
        drive_ack = 1'b0;
        if (en_mode == 1) enable = 1'b0;
        if (en_mode == 2) begin
            repeat (10) cyc();
            chk("in_ride", 32'(phase), 32'd3);
            enable = 1'b0;
        end
        wait_idle(60);
    endtask

    initial begin
        logic okv;
        rst = 1'b1; enable = 1'b0; queue_count = 5'd0; drive_ack = 1'b0; estop = 1'b0;
        repeat (3) cyc();
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_req", 32'(drive_req), 32'd0);
        chk("rst_ledg", 32'(ledg), 32'd0);
        chk("rst_hex", 32'(hex5), 32'(BLANK));
        chk("rst_rides", 32'(rides_done), 32'd0);
        rst = 1'b0;
        repeat (2) cyc();

        // Basic dispatch, ack 3 cycles after drive_req rises.
        run_ride(3, 1, 0);
        chk("basic_rides", 32'(rides_done), 32'd1);
        repeat (3) cyc();

        // Insufficient queue / boundary / enable low: nothing may happen.
        okv = 1'b1;
        enable = 1'b1; queue_count = 5'd4;
        repeat (50) begin cyc(); if (phase != 0 || drive_req || hex5 != BLANK) okv = 1'b0; end
        queue_count = 5'd7;
        repeat (20) begin cyc(); if (phase != 0 || drive_req || hex5 != BLANK) okv = 1'b0; end
        enable = 1'b0; queue_count = 5'd20;
        repeat (10) begin cyc(); if (phase != 0 || drive_req || hex5 != BLANK) okv = 1'b0; end
        chk("no_dispatch", 32'(okv), 32'd1);

        // Withdraw: exactly BATCH dispatches, then the queue drops before ack.
        queue_count = 5'd8; enable = 1'b1;
        push(3'd1, 0, 1'b1, 4'b0001, BLANK, exp_rides);
        push(3'd0, 1, 1'b0, 4'b0000, BLANK, exp_rides);
        cyc();
        chk("wd_req_hi", 32'(drive_req), 32'd1);
        queue_count = 5'd4;
        cyc();
        chk("wd_phase", 32'(phase), 32'd0);
        chk("wd_req_lo", 32'(drive_req), 32'd0);
        chk("wd_rides", 32'(rides_done), 32'(exp_rides));
        enable = 1'b0;
        repeat (3) cyc();

        // Ack and enable drop in the same REQUEST cycle; enable drop in RIDE.
        run_ride(3, 0, 0);
        repeat (2) cyc();
        run_ride(2, 2, 0);
        chk("en_drop_rides", 32'(rides_done), 32'd3);
        repeat (2) cyc();

        // Async reset in RIDE with timer=2.
        queue_count = 5'd12; enable = 1'b1;
        push(3'd1, 0, 1'b1, 4'b0001, BLANK, exp_rides);
        push(3'd2, 3, 1'b0, 4'b0010, D2,    exp_rides);
        push(3'd3, 8, 1'b0, 4'b0100, D3,    exp_rides);
        cyc(); cyc(); cyc();
        drive_ack = 1'b1; enable = 1'b0;
        cyc();
        drive_ack = 1'b0;
        repeat (8) cyc();
        repeat (5) cyc();
        chk("pre_rst_hex", 32'(hex5), 32'(D2));
        #2 rst = 1'b1;
        #1;
        chk("arst_phase", 32'(phase), 32'd0);
        chk("arst_req", 32'(drive_req), 32'd0);
        chk("arst_ledg", 32'(ledg), 32'd0);
        chk("arst_rides", 32'(rides_done), 32'd0);
        chk("arst_hex", 32'(hex5), 32'(BLANK));
        exp_rides = 8'd0;
        cyc();
        rst = 1'b0;
        repeat (2) cyc();

`ifdef RIDE_ESTOP_EN
        // Estop in RIDE: UNLOAD next cycle, no ride counted.
        queue_count = 5'd12; enable = 1'b1;
        push(3'd1, 0, 1'b1, 4'b0001, BLANK, exp_rides);
        push(3'd2, 3, 1'b0, 4'b0010, D2,    exp_rides);
        push(3'd3, 8, 1'b0, 4'b0100, D3,    exp_rides);
        push(3'd4, 1, 1'b0, 4'b1000, D1,    exp_rides);
        push(3'd0, 4, 1'b0, 4'b0000, BLANK, exp_rides);
        cyc(); cyc(); cyc();
        drive_ack = 1'b1; enable = 1'b0;
        cyc();
        drive_ack = 1'b0;
        repeat (8) cyc();
        estop = 1'b1;
        cyc();
        estop = 1'b0;
        chk("estop_unload", 32'(phase), 32'd4);
        wait_idle(30);
        chk("estop_rides", 32'(rides_done), 32'd0);
        repeat (2) cyc();
`endif

        // 256 back-to-back rides: no dead time, counter saturates at 255.
        for (int i = 0; i < 256; i++) run_ride(1, 3, (i == 0) ? 0 : 1);
        enable = 1'b0;
        chk("sat_rides", 32'(rides_done), 32'd255);
        repeat (5) cyc();
        chk("drain", expq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
